// File: rtl/minterm_sweeper_pkg.sv
// Shared definitions for the minterm sweeper: FSM state encoding and table sizing.
package minterm_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam int DEFAULT_N = 4;

    // Every select code gets one table bit, so the table width follows from N.
    localparam int DEFAULT_TBL_W = 2 ** DEFAULT_N;

endpackage

// File: rtl/minterm_sweeper_sweep_index_counter.sv
// N-bit up-counter with synchronous clear, count enable and terminal-count flag.
module sweep_index_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + N'(1);
        end
    end

    assign tc = (count == {N{1'b1}});

endmodule

// File: rtl/minterm_sweeper.sv
// Steps a downstream decoder through every select code and captures its output as a truth table.
// Optional macro MINTERM_SWEEPER_COUNT_EN adds ones_cnt, the population count of the captured table.
module minterm_sweeper
    import minterm_sweeper_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int TBL_W = 2 ** N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             f_in,
    output logic [N-1:0]     w_out,
    output logic             en_out,
    output logic             busy,
    output logic             done,
`ifdef MINTERM_SWEEPER_COUNT_EN
    output logic [N:0]       ones_cnt,
`endif
    output logic [TBL_W-1:0] table_out
);

    sweep_state_t state, state_next;
    logic [N-1:0] index;
    logic         index_tc;
    logic         launch;
    logic         sample;

    // abort outranks start when both arrive while idle
    assign launch = (state == IDLE) && start && !abort;
    assign sample = (state == SWEEP) && !abort;

    sweep_index_counter #(
        .N(N)
    ) u_index (
        .clk   (clk),
        .reset (reset),
        .clr   (state != SWEEP),
        .en    (sample),
        .count (index),
        .tc    (index_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = SWEEP;
            SWEEP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (index_tc) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign en_out = (state == SWEEP);
    assign w_out  = (state == SWEEP) ? index : '0;
    assign busy   = (state == SWEEP);
    assign done   = (state == DONE);

    // f_in is combinational from w_out, so it is captured in the same cycle the code is shown
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            table_out <= '0;
        end else if (sample) begin
            table_out[index] <= f_in;
        end
    end

`ifdef MINTERM_SWEEPER_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            ones_cnt <= '0;
        end else if (sample) begin
            ones_cnt <= ones_cnt + {{N{1'b0}}, f_in};
        end
    end
`endif

endmodule
